seq_rotator: RTL and testbench
==============================

# seq_rotator

Iterative rotator that rotates an 8-bit word left or right by 0-7 positions, one bit position per clock, under a start/busy/done handshake. It is the low-area sequential counterpart to the combinational multi-barrel rotator. It uses the same `lr` convention (1 = left, 0 = right), so its results can be checked against, or used to undo, the barrel rotator's output. It sits between a requesting controller and the datapath; the controller issues one request and waits for `done`.

## Interface
Parameters:
- `WIDTH`, 8: data word width. Must equal 2**`SHW`.
- `SHW`, 3: width of the rotate-amount field.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe. Sampled only in IDLE.
- `lr`  in  1  direction, latched at accept. 1 = rotate left, 0 = rotate right.
- `amt`  in  `SHW`  rotate amount 0-7, latched at accept.
- `din`  in  `WIDTH`  word to rotate, latched at accept.
- `busy`  out  1  high while in ROTATE.
- `done`  out  1  one-cycle pulse; high exactly while in DONE.
- `dout`  out  `WIDTH`  working/result register. Valid when `done`=1 and held until the next accepted `start`.

## Operation
- Internal registers: `data`[`WIDTH`], `cnt`[`SHW`], `dir`[1], and a state register (IDLE, ROTATE, DONE).
- IDLE with `start`=1: load `data`<=`din`, `cnt`<=`amt`, `dir`<=`lr`.
  - If `amt`=0, next state is DONE.
  - Otherwise next state is ROTATE.
- IDLE with `start`=0: hold all registers.
- ROTATE, each cycle:
  - `dir`=1: `data`<={`data`[`WIDTH`-2:0], `data`[`WIDTH`-1]}.
  - `dir`=0: `data`<={`data`[0], `data`[`WIDTH`-1:1]}.
  - `cnt`<=`cnt`-1.
  - If `cnt`=1 before the decrement, next state is DONE. Otherwise stay in ROTATE.
- DONE: hold `data`; next state is IDLE unconditionally.
- `start` is ignored in ROTATE and DONE. It is neither queued nor remembered.
- `dout` = `data` at all times. It shows intermediate values during ROTATE; consumers sample it only when `done`=1.
- `busy` = (state==ROTATE). `done` = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Net result equals a combinational rotate of `din` by `amt` in direction `lr`. Rotating left by k equals rotating right by 8-k.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge): state=IDLE, `data`=0, `cnt`=0, `dir`=0, so `busy`=0, `done`=0, `dout`=8'h00. Reset takes priority over `start`.
- Accept happens at the edge where state=IDLE and `start`=1; call it edge k.
- Latency:
  - DONE is entered at edge k+`amt` for every `amt` in 0-7, including 0.
  - `done` is high for the cycle after that edge.
  - For `amt`≥1, `busy` is high for exactly `amt` cycles, starting after edge k.
- Throughput: the earliest next accept is the edge ending the DONE cycle plus one, i.e. the IDLE cycle after DONE. `start` held high continuously is accepted once per `amt`+2 cycles.
- Reset mid-operation (ROTATE or DONE): abort to IDLE next edge, no `done` pulse, `dout`=0.
- `cnt` never wraps: ROTATE is entered only with `cnt`≥1 and exits on 1.
- Changes to `din`, `amt` or `lr` after accept have no effect on the operation in progress.

## Test plan
- Reset, then `din`=8'hB1, `lr`=1, `amt`=3, `start` pulse → `busy` high 3 cycles; `done` pulse one cycle later with `dout`=8'h8D.
- `din`=8'hB1, `lr`=0, `amt`=3 → `done` after 3 rotate cycles, `dout`=8'h36. Then `lr`=1, `amt`=7 on 8'hB1 → `dout`=8'hD8, equal to a right rotate by 1.
- `amt`=0, `din`=8'h5A → `busy` never high; `done` in the cycle after accept with `dout`=8'h5A.
- During a ROTATE with `amt`=5, pulse `start` with `din`=8'hFF → ignored; the original result completes unchanged and exactly one `done` pulse occurs.
- Assert `reset` in the 2nd ROTATE cycle → IDLE next edge, `busy`=0, `done` never pulses, `dout`=8'h00. A subsequent request completes normally.
- Round trip: rotate 8'hC3 left by 5, feed the result back with `lr`=0, `amt`=5 → final `dout`=8'hC3. Sweep all `amt`/`lr` combinations against a reference rotate model.

Source files
------------

// File: rtl/seq_rotator.sv
// seq_rotator: iterative rotator that moves a WIDTH-bit word one bit
// position per clock, left or right, by 0..2**SHW-1 positions, under a
// start/busy/done handshake. The lr convention (1 = left, 0 = right) matches
// the combinational barrel rotator, so results can be cross-checked or undone.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   start  in   request strobe, sampled only in IDLE
//   lr     in   direction, latched at accept (1 = left, 0 = right)
//   amt    in   [SHW]   rotate amount, latched at accept
//   din    in   [WIDTH] word to rotate, latched at accept
//   busy   out  high while rotating
//   done   out  one-cycle pulse when the result is ready
//   dout   out  [WIDTH] working/result register; valid while done=1 and held
//               until the next accepted start

module seq_rotator #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             lr,
    input  logic [SHW-1:0]   amt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir;

    // State register plus the datapath registers it steers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data <= din;
                        r_cnt  <= amt;
                        r_dir  <= lr;
                    end
                end
                S_ROTATE: begin
                    if (r_dir)
                        r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                    else
                        r_data <= {r_data[0], r_data[WIDTH-1:1]};
                    r_cnt <= r_cnt - SHW'(1);
                end
                default: begin
                    // DONE holds the result for the consumer.
                end
            endcase
        end
    end

    // Next-state decode. A zero amount skips ROTATE entirely so DONE lands
    // at accept + amt for every amount, including 0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = (amt == '0) ? S_DONE : S_ROTATE;
            end
            S_ROTATE: begin
                // Exit on the last step; cnt is never 0 here, so it cannot wrap.
                if (r_cnt == SHW'(1))
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Decoded straight from registered state, so both are glitch-free.
    assign busy = (r_state == S_ROTATE);
    assign done = (r_state == S_DONE);
    assign dout = r_data;

endmodule

// File: tb/tb_seq_rotator.sv
module tb_seq_rotator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       lr;
    logic [2:0] amt;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    seq_rotator #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .lr    (lr),
        .amt   (amt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       lr;
        logic [2:0] amt;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rotate built bit by bit, independent of the shift form.
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic l, input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (l) r[(i + k) % 8] = d[i];
            else   r[i] = d[(i + k) % 8];
        end
        return r;
    endfunction

    // Issue one request, then check busy length, done timing and result.
    task automatic run_op(input logic [7:0] d, input logic l, input logic [2:0] a,
                          input logic [7:0] exp, input string name);
        int bc;
        int cyc;
        bit got;
        @(negedge clk);
        din = d; lr = l; amt = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din = ~d; lr = ~l; amt = ~a;   // post-accept changes must not matter
        bc = 0; got = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (busy && done) chk({name, " busy&done"}, 1, 0);
            if (done) begin got = 1; break; end
            if (busy) bc++;
            @(posedge clk); #1;
        end
        chk({name, " done_seen"}, got, 1);
        chk({name, " done_lat"}, cyc, a);
        chk({name, " busy_cyc"}, bc, a);
        chk({name, " dout"}, dout, exp);
        @(posedge clk); #1;
        chk({name, " done_1cyc"}, done, 0);
        chk({name, " dout_hold"}, dout, exp);
    endtask

    initial begin
        int dcount;
        int tmo;
        logic [7:0] mid;

        vecs[0] = '{8'hB1, 1'b1, 3'd3, 8'h8D, "B1_l3"};
        vecs[1] = '{8'hB1, 1'b0, 3'd3, 8'h36, "B1_r3"};
        vecs[2] = '{8'hB1, 1'b1, 3'd7, 8'hD8, "B1_l7"};
        vecs[3] = '{8'h5A, 1'b0, 3'd0, 8'h5A, "5A_0"};
        vecs[4] = '{8'h01, 1'b0, 3'd1, 8'h80, "01_r1"};
        vecs[5] = '{8'h80, 1'b1, 3'd1, 8'h01, "80_l1"};

        reset = 1'b1; start = 1'b1; lr = 1'b1; amt = 3'd2; din = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 8'h00);
        start = 1'b0;
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].din, vecs[i].lr, vecs[i].amt, vecs[i].exp, vecs[i].name);

        // start during ROTATE is ignored; exactly one done pulse
        @(negedge clk);
        din = 8'hB1; lr = 1'b1; amt = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        din = 8'hFF; amt = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0; mid = 8'h00;
        for (int c = 0; c < 12; c++) begin
            if (done) begin dcount++; mid = dout; end
            @(posedge clk); #1;
        end
        chk("ign_done_cnt", dcount, 1);
        chk("ign_dout", mid, 8'h36);

        // reset in the 2nd ROTATE cycle aborts with no done
        @(negedge clk);
        din = 8'hB1; lr = 1'b1; amt = 3'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_pre", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dout", dout, 8'h00);
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || busy) dcount++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", dcount, 0);
        run_op(8'h3C, 1'b0, 3'd2, 8'h0F, "post_abort");

        // round trip
        run_op(8'hC3, 1'b1, 3'd5, 8'h78, "rt_fwd");
        run_op(8'h78, 1'b0, 3'd5, 8'hC3, "rt_back");

        // sweep against the reference model
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < 8; a++)
                run_op(8'h96, l[0], a[2:0], rot_ref(8'h96, l[0], a), $sformatf("sw_l%0d_a%0d", l, a));

        // held start: accepted once per amt+2 cycles
        @(negedge clk);
        din = 8'h11; lr = 1'b1; amt = 3'd2; start = 1'b1;
        dcount = 0; tmo = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        start = 1'b0;
        chk("held_start_done", dcount, 4);
        tmo = 0;
        while ((busy || done) && tmo < 20) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("held_start_drain", tmo < 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
